// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light monitor: light codes, road indices,
// tracker states, error bit positions and the first-error encoder.
package tl_pkg;

  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_GREEN  = 3'b001;

  localparam int ROAD_M1   = 0;
  localparam int ROAD_M2   = 1;
  localparam int ROAD_MT   = 2;
  localparam int ROAD_S    = 3;
  localparam int NUM_ROADS = 4;

  typedef enum logic [1:0] {
    TS_UNARMED,
    TS_RED,
    TS_YELLOW,
    TS_GREEN
  } track_state_t;

  localparam int ERR_ENC      = 0;
  localparam int ERR_CONFLICT = 1;
  localparam int ERR_SEQ      = 2;
  localparam int ERR_DWELL    = 3;
  localparam int ERR_STARVE   = 4;
  localparam int NUM_ERR      = 5;

  // Starvation has no spare one-hot position in the 4-bit type field.
  localparam logic [3:0] CODE_STARVE = 4'b1111;

  typedef logic [NUM_ERR-1:0] err_vec_t;
  typedef logic [NUM_ROADS-1:0][NUM_ERR-1:0] road_err_t;

  // {valid, road, type} of the lowest road, then lowest error bit, that is set.
  function automatic logic [6:0] encode_first(input road_err_t errs);
    logic [6:0] word;
    word = '0;
    for (int r = NUM_ROADS - 1; r >= 0; r--) begin
      for (int b = NUM_ERR - 1; b >= 0; b--) begin
        if (errs[r][b]) begin
          word = {1'b1, 2'(r), (b == ERR_STARVE) ? CODE_STARVE : 4'(1 << b)};
        end
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/tl_road_tracker.sv
// Per-road colour tracker: follows one light bus and flags encoding, sequence,
// dwell and (with TLMON_STARVE_EN defined) red-starvation violations.
module tl_road_tracker
  import tl_pkg::*;
#(
  parameter int MIN_GREEN  = 3,
  parameter int MIN_YELLOW = 2,
  parameter int CNT_W      = 8,
  parameter int MAX_RED    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  output logic       enc_err,
  output logic       seq_err,
  output logic       dwell_err,
  output logic       starve_err,
  output logic       active,
  output logic       green
);

  if (MAX_RED < 1 || MAX_RED >= 2 ** CNT_W) begin : g_bad_max_red
    $error("tl_road_tracker: MAX_RED must lie in 1 .. 2**CNT_W-1");
  end

  track_state_t     state;
  track_state_t     sample_state;
  logic [CNT_W-1:0] dwell;
  logic             legal;
  logic             armed;
  logic             changed;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    legal        = 1'b1;
    sample_state = state;
    case (light)
      LT_RED:    sample_state = TS_RED;
      LT_YELLOW: sample_state = TS_YELLOW;
      LT_GREEN:  sample_state = TS_GREEN;
      default:   legal        = 1'b0;
    endcase
  end

  assign armed   = (state != TS_UNARMED);
  assign changed = legal && armed && (sample_state != state);
  assign enc_err = !legal;
  assign green   = (light == LT_GREEN);
  assign active  = (light == LT_GREEN) || (light == LT_YELLOW);

  always_comb begin
    seq_err   = 1'b0;
    dwell_err = 1'b0;
    if (changed) begin
      case (state)
        TS_GREEN: begin
          if (sample_state != TS_YELLOW)        seq_err   = 1'b1;
          else if (dwell < CNT_W'(MIN_GREEN))   dwell_err = 1'b1;
        end
        TS_YELLOW: begin
          if (sample_state != TS_RED)           seq_err   = 1'b1;
          else if (dwell < CNT_W'(MIN_YELLOW))  dwell_err = 1'b1;
        end
        TS_RED: begin
          if (sample_state != TS_GREEN)         seq_err   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TS_UNARMED;
      dwell <= '0;
    end else if (legal && (!armed || sample_state != state)) begin
      state <= sample_state;
      dwell <= CNT_W'(1);
    end else if (armed) begin
      // Same colour, or an illegal code while the previous colour is held.
      dwell <= (dwell == '1) ? dwell : dwell + 1'b1;
    end
  end

`ifdef TLMON_STARVE_EN
  logic [CNT_W-1:0] red_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      red_cnt <= '0;
    end else if (legal) begin
      if (sample_state == TS_RED) red_cnt <= (red_cnt == '1) ? red_cnt : red_cnt + 1'b1;
      else                        red_cnt <= '0;
    end
  end

  // Fires only on the MAX_RED-th consecutive red sample, so one pulse per red spell.
  assign starve_err = legal && (sample_state == TS_RED) && (red_cnt == CNT_W'(MAX_RED - 1));
`else
  assign starve_err = 1'b0;
`endif

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the four traffic-light buses; reports sticky flags, a
// violation pulse, a saturating count and first-error capture. Optional: TLMON_STARVE_EN.
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int MIN_GREEN  = 3,
  parameter int MIN_YELLOW = 2,
  parameter int CNT_W      = 8,
  parameter int MAX_RED    = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       light_M1,
  input  logic [2:0]       light_M2,
  input  logic [2:0]       light_MT,
  input  logic [2:0]       light_S,
  input  logic             clr,
  output logic [4:0]       err_flags,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [6:0]       first_err
);

  logic [2:0]           lights [NUM_ROADS];
  logic [NUM_ROADS-1:0] active, green, enc, seq, dwell, starve, conflict;
  logic                 s_vs_main, mt_vs_m1, any_err;
  road_err_t            road_err;
  err_vec_t             type_hits, flags_base;
  logic [CNT_W-1:0]     count_base;
  logic [6:0]           first_base;

  assign lights[ROAD_M1] = light_M1;
  assign lights[ROAD_M2] = light_M2;
  assign lights[ROAD_MT] = light_MT;
  assign lights[ROAD_S]  = light_S;

  for (genvar r = 0; r < NUM_ROADS; r++) begin : g_road
    tl_road_tracker #(
      .MIN_GREEN (MIN_GREEN),
      .MIN_YELLOW(MIN_YELLOW),
      .CNT_W     (CNT_W),
      .MAX_RED   (MAX_RED)
    ) u_tracker (
      .clk       (clk),
      .rst       (rst),
      .light     (lights[r]),
      .enc_err   (enc[r]),
      .seq_err   (seq[r]),
      .dwell_err (dwell[r]),
      .starve_err(starve[r]),
      .active    (active[r]),
      .green     (green[r])
    );
  end

  // Each road taking part in a conflict is charged with it, so first_err
  // names the lowest-indexed road involved.
  assign s_vs_main = active[ROAD_S] &&
                     (active[ROAD_M1] || active[ROAD_M2] || active[ROAD_MT]);
  assign mt_vs_m1  = green[ROAD_MT] && green[ROAD_M1];

  assign conflict[ROAD_M1] = (s_vs_main && active[ROAD_M1]) || mt_vs_m1;
  assign conflict[ROAD_M2] =  s_vs_main && active[ROAD_M2];
  assign conflict[ROAD_MT] = (s_vs_main && active[ROAD_MT]) || mt_vs_m1;
  assign conflict[ROAD_S]  =  s_vs_main;

  always_comb begin
    type_hits = '0;
    for (int r = 0; r < NUM_ROADS; r++) begin
      road_err[r]               = '0;
      road_err[r][ERR_ENC]      = enc[r];
      road_err[r][ERR_CONFLICT] = conflict[r];
      road_err[r][ERR_SEQ]      = seq[r];
      road_err[r][ERR_DWELL]    = dwell[r];
      road_err[r][ERR_STARVE]   = starve[r];
      type_hits                 = type_hits | road_err[r];
    end
  end

  assign any_err = |type_hits;

  // clr zeroes the base values; a same-cycle violation is then applied on top.
  assign flags_base = clr ? '0 : err_flags;
  assign count_base = clr ? '0 : err_count;
  assign first_base = clr ? '0 : first_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flags <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
      first_err <= '0;
    end else begin
      err_flags <= flags_base | type_hits;
      err_pulse <= any_err;
      if (any_err && count_base != '1) err_count <= count_base + 1'b1;
      else                             err_count <= count_base;
      if (any_err && !first_base[6])   first_err <= encode_first(road_err);
      else                             first_err <= first_base;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor; expected values are
// hand-computed per scenario. Honours TLMON_STARVE_EN for the starvation test.
module tb_traffic_light_monitor;

  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] BAD = 3'b110;
  localparam int         TB_MAX_RED = 10;

  logic       clk = 1'b0;
  logic       rst, clr;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic [4:0] err_flags;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [6:0] first_err;

  int checks    = 0;
  int errors    = 0;
  int pulse_cnt = 0;

  traffic_light_monitor #(
    .MIN_GREEN (3),
    .MIN_YELLOW(2),
    .CNT_W     (8),
    .MAX_RED   (TB_MAX_RED)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .light_M1 (light_M1),
    .light_M2 (light_M2),
    .light_MT (light_MT),
    .light_S  (light_S),
    .clr      (clr),
    .err_flags(err_flags),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .first_err(first_err)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after an edge; outputs are read there, reflecting the sample just taken.
  task automatic step();
    @(posedge clk);
    #1;
    if (err_pulse === 1'b1) pulse_cnt++;
  endtask

  task automatic drive(input logic [2:0] m1, m2, mt, s, input int n);
    light_M1 = m1; light_M2 = m2; light_MT = mt; light_S = s;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0;
    light_M1 = R; light_M2 = R; light_MT = R; light_S = R;
    step();
    rst = 1'b0;
    pulse_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (err_flags !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected %b", err_flags, 5'b0); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", err_pulse); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", err_count); end
    checks++; if (first_err !== 7'b0) begin errors++; $display("FAIL reset_first: got %b expected %b", first_err, 7'b0); end
  endtask

  task automatic test_legal_cycle();
    do_reset();
    repeat (3) begin
      drive(G, G, R, R, 5);
      drive(Y, Y, R, R, 2);
      drive(R, R, R, G, 5);
      drive(R, R, R, Y, 2);
    end
    drive(R, R, R, R, 1);
`ifdef TLMON_STARVE_EN
    // The turn road never goes green here, so only the non-starvation bits are meaningful.
    checks++; if (err_flags[3:0] !== 4'b0) begin errors++; $display("FAIL legal_flags: got %b expected 0000", err_flags[3:0]); end
`else
    checks++; if (err_flags !== 5'b0) begin errors++; $display("FAIL legal_flags: got %b expected %b", err_flags, 5'b0); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL legal_count: got %0d expected 0", err_count); end
    checks++; if (pulse_cnt != 0) begin errors++; $display("FAIL legal_pulses: got %0d expected 0", pulse_cnt); end
`endif
  endtask

  task automatic test_conflict();
    do_reset();
    drive(R, R, R, R, 1);
    drive(G, R, R, G, 1);
    checks++; if (err_flags !== 5'b00010) begin errors++; $display("FAIL conflict_flags_1: got %b expected %b", err_flags, 5'b00010); end
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL conflict_pulse: got %b expected 1", err_pulse); end
    drive(G, R, R, G, 1);
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL conflict_count: got %0d expected 2", err_count); end
    checks++; if (first_err !== 7'b1_00_0010) begin errors++; $display("FAIL conflict_first: got %b expected %b", first_err, 7'b1_00_0010); end
  endtask

  task automatic test_sequence();
    do_reset();
    drive(R, R, R, R, 1);
    drive(R, G, R, R, 4);
    drive(R, R, R, R, 1);
    checks++; if (err_flags !== 5'b00100) begin errors++; $display("FAIL seq_flags: got %b expected %b", err_flags, 5'b00100); end
    checks++; if (first_err !== 7'b1_01_0100) begin errors++; $display("FAIL seq_first: got %b expected %b", first_err, 7'b1_01_0100); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL seq_count: got %0d expected 1", err_count); end
  endtask

  task automatic test_dwell();
    do_reset();
    drive(R, R, R, R, 1);
    drive(R, R, G, R, 1);
    drive(R, R, Y, R, 1);
    checks++; if (err_flags !== 5'b01000) begin errors++; $display("FAIL dwell_flags: got %b expected %b", err_flags, 5'b01000); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL dwell_count: got %0d expected 1", err_count); end
    checks++; if (first_err !== 7'b1_10_1000) begin errors++; $display("FAIL dwell_first: got %b expected %b", first_err, 7'b1_10_1000); end
    drive(R, R, Y, BAD, 1);
    checks++; if (err_flags !== 5'b01001) begin errors++; $display("FAIL enc_flags: got %b expected %b", err_flags, 5'b01001); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL enc_count: got %0d expected 2", err_count); end
    checks++; if (first_err !== 7'b1_10_1000) begin errors++; $display("FAIL enc_first_kept: got %b expected %b", first_err, 7'b1_10_1000); end
  endtask

  task automatic test_dwell_boundary();
    do_reset();
    drive(R, R, R, R, 1);
    drive(R, R, G, R, 3);
    drive(R, R, Y, R, 1);
    checks++; if (err_flags !== 5'b0) begin errors++; $display("FAIL dwell_green_min: got %b expected %b", err_flags, 5'b0); end
    drive(R, R, R, R, 1);
    checks++; if (err_flags !== 5'b01000) begin errors++; $display("FAIL dwell_yellow_short: got %b expected %b", err_flags, 5'b01000); end
    checks++; if (first_err !== 7'b1_10_1000) begin errors++; $display("FAIL dwell_yellow_first: got %b expected %b", first_err, 7'b1_10_1000); end
  endtask

  task automatic test_reset_clr();
    do_reset();
    drive(R, R, R, R, 1);
    drive(G, G, R, R, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    pulse_cnt = 0;
    drive(R, R, R, R, 2);
    checks++; if (err_flags !== 5'b0) begin errors++; $display("FAIL midreset_flags: got %b expected %b", err_flags, 5'b0); end
    checks++; if (pulse_cnt != 0) begin errors++; $display("FAIL midreset_pulses: got %0d expected 0", pulse_cnt); end
    drive(R, R, R, 3'b111, 1);
    checks++; if (first_err !== 7'b1_11_0001) begin errors++; $display("FAIL enc_s_first: got %b expected %b", first_err, 7'b1_11_0001); end
    clr = 1'b1;
    drive(R, R, R, R, 1);
    checks++; if ({err_flags, err_count, first_err} !== 20'b0) begin errors++; $display("FAIL clr_alone: got flags %b count %0d first %b expected all 0", err_flags, err_count, first_err); end
    drive(G, R, R, G, 1);
    clr = 1'b0;
    checks++; if (err_flags !== 5'b00010) begin errors++; $display("FAIL clr_conflict_flags: got %b expected %b", err_flags, 5'b00010); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL clr_conflict_count: got %0d expected 1", err_count); end
    checks++; if (first_err !== 7'b1_00_0010) begin errors++; $display("FAIL clr_conflict_first: got %b expected %b", first_err, 7'b1_00_0010); end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(R, R, R, R, 1);
    drive(G, R, R, G, 260);
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL count_saturate: got %0d expected 255", err_count); end
    checks++; if (err_flags[1] !== 1'b1) begin errors++; $display("FAIL saturate_conflict_flag: got %b expected 1", err_flags[1]); end
  endtask

  task automatic test_starvation();
    do_reset();
`ifdef TLMON_STARVE_EN
    drive(R, R, R, R, TB_MAX_RED - 1);
    checks++; if (err_flags[4] !== 1'b0) begin errors++; $display("FAIL starve_early: got %b expected 0", err_flags[4]); end
    drive(R, R, R, R, 1);
    checks++; if (err_flags !== 5'b10000) begin errors++; $display("FAIL starve_flags: got %b expected %b", err_flags, 5'b10000); end
    checks++; if (first_err !== 7'b1_00_1111) begin errors++; $display("FAIL starve_first: got %b expected %b", first_err, 7'b1_00_1111); end
    drive(R, R, R, R, 3);
    checks++; if (pulse_cnt != 1) begin errors++; $display("FAIL starve_pulses: got %0d expected 1", pulse_cnt); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL starve_count: got %0d expected 1", err_count); end
`else
    drive(R, R, R, R, TB_MAX_RED + 2);
    checks++; if (err_flags !== 5'b0) begin errors++; $display("FAIL starve_disabled_flags: got %b expected %b", err_flags, 5'b0); end
    checks++; if (pulse_cnt != 0) begin errors++; $display("FAIL starve_disabled_pulses: got %0d expected 0", pulse_cnt); end
`endif
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    light_M1 = R; light_M2 = R; light_MT = R; light_S = R;
    test_reset();
    test_legal_cycle();
    test_conflict();
    test_sequence();
    test_dwell();
    test_dwell_boundary();
    test_reset_clr();
    test_saturation();
    test_starvation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the receiving end of the trafficlight controller's four light buses (M1, M2, MT, S).
- Samples all four roads every clock and checks:
  - light encoding,
  - cross-road conflicts,
  - per-road colour sequence,
  - minimum green/yellow dwell times.
- Reports violations as registered sticky flags, a per-violation pulse, a saturating error count and a first-error capture.
- Sits beside the controller in the top level and in the benches; it never drives the lights.

Parameters:
- MIN_GREEN, 3, minimum cycles a road must stay green before going yellow
- MIN_YELLOW, 2, minimum cycles a road must stay yellow before going red
- CNT_W, 8, width of the error counter and the dwell counters (both saturate at all-ones)
- MAX_RED, 60, starvation limit in cycles (used only with TLMON_STARVE_EN)

Ports:
- clk  input  1  system clock (1 cycle = 1 s in system benches)
- rst  input  1  synchronous, active-high reset
- light_M1  input  3  main road direction 1 light
- light_M2  input  3  main road direction 2 light
- light_MT  input  3  main road turn light
- light_S  input  3  side road light
- clr  input  1  synchronous clear of flags, count and capture
- err_flags  output  5  sticky: [0] encoding, [1] conflict, [2] sequence, [3] dwell, [4] starvation
- err_pulse  output  1  high for one cycle per cycle in which any violation is detected
- err_count  output  CNT_W  number of violating cycles, saturating
- first_err  output  7  {valid, road[1:0], type[3:0]} of the first violation since reset/clr

Behaviour:
- Encoding: red = 3'b100, yellow = 3'b010, green = 3'b001. Any other value is an encoding error.
- Road index: M1 = 0, M2 = 1, MT = 2, S = 3.
- Reset (rst = 1 at a clk edge):
  - err_flags = 0, err_pulse = 0, err_count = 0, first_err = 0.
  - All trackers go to UNARMED with dwell = 0.
- Tracker states per road: UNARMED, RED, YELLOW, GREEN.
  - The first legal sample after reset loads the state with no sequence check; dwell = 1.
- Legal transitions: GREEN→YELLOW, YELLOW→RED, RED→GREEN, or the same colour (dwell increments, saturating).
  - Any other change (GREEN→RED, RED→YELLOW, YELLOW→GREEN) raises a sequence error.
  - The state still follows the new colour and dwell restarts at 1.
- Dwell checks:
  - GREEN→YELLOW with dwell < MIN_GREEN raises a dwell error.
  - YELLOW→RED with dwell < MIN_YELLOW raises a dwell error.
- Illegal code on a road:
  - Raises an encoding error.
  - Tracker state is held; dwell keeps counting.
  - Sequence, dwell and conflict checks are skipped for that road in that cycle.
- Conflicts (legal codes only; "active" = green or yellow):
  - S active together with any of M1, M2 or MT active.
  - MT green together with M1 green.
  - M1 and M2 both green is legal; M2 and MT both green is legal.
- Latency: detection is combinational on the sample; all outputs are registered and update at the next clk edge (1-cycle latency).
- Simultaneous violations:
  - All corresponding flag bits are set in the same cycle.
  - err_count increments by exactly 1.
  - first_err records the lowest road index, then the lowest type bit.
- first_err is written only when valid = 0.
- clr:
  - Clears flags, count and first_err.
  - Does not affect the trackers.
  - A violation in the same cycle as clr wins: the register ends holding that violation.
- Reset mid-operation: all trackers return to UNARMED. No false sequence or dwell error is raised on the first sample after reset.

Optional Feature:
- Macro: TLMON_STARVE_EN.
- Defined:
  - Each armed tracker counts consecutive RED cycles.
  - Reaching MAX_RED sets err_flags[4] (type bit 4 in first_err uses the code 4'b1111) with one err_pulse.
  - The flag re-arms only after the road leaves red.
- Undefined: err_flags[4] is tied to 0, and no red counter logic is generated.

Decomposition:
- Package tl_pkg:
  - Light code constants (LT_RED, LT_YELLOW, LT_GREEN).
  - Road index constants.
  - Tracker state typedef.
  - Error bit positions.
- Sub-module tl_road_tracker, instantiated four times:
  - Owns one road's state, dwell counter, optional red counter, encoding/sequence/dwell detection.
  - Exports a decoded active/green status.
- The top level holds the conflict logic, the error aggregation and the output registers.

Test Plan:
- Legal cycle: M1 and M2 green 5 cycles, yellow 2, red; then S green 5, yellow 2, red; repeat 3 times → err_flags = 0, err_count = 0, err_pulse never high.
- Conflict: S = 3'b001 while M1 = 3'b001 for 2 cycles → err_flags[1] = 1 one cycle later, err_count = 2, first_err = {1, 2'd0, 4'b0010}.
- Sequence: M2 goes green→red directly after 4 green cycles → err_flags[2] = 1, first_err = {1, 2'd1, 4'b0100}.
- Dwell: MT green for 1 cycle, then yellow → err_flags[3] = 1, err_count = 1. An encoding value of 3'b110 on S the next cycle sets err_flags[0], count = 2, first_err unchanged.
- Reset and clr: rst pulse mid-green, then lights resume at red → no errors. clr coincident with a conflict → flags = 5'b00010, count = 1.
- TLMON_STARVE_EN defined, MAX_RED = 10: S held red for 10 cycles → err_flags[4] = 1 and exactly one pulse. With the macro undefined → err_flags[4] = 0.
